// File: rtl/tile_pkg.sv
// Shared types and default geometry for the tile scheduler and its helpers.
package tile_pkg;

    localparam int IMG_W   = 400;
    localparam int IMG_H   = 400;
    localparam int TILE    = 10;
    localparam int TILES_X = IMG_W / TILE;
    localparam int TILES_Y = IMG_H / TILE;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        ADVANCE,
        PAUSE,
        FINISH
    } sched_state_t;

    typedef enum logic {
        RUN,
        STEP
    } mode_t;

    // Full-width unsigned pixel address of a tile's top-left corner.
    function automatic logic [31:0] tile_base(input logic [5:0] tx, input logic [5:0] ty,
                                              input int tile, input int img_w);
        return (32'(ty) * 32'(tile)) * 32'(img_w) + 32'(tx) * 32'(tile);
    endfunction

endpackage

// File: rtl/button_event.sv
// Raw button to single-cycle press event: 2-FF synchronizer, stability filter,
// and a pulse on the accepted 0->1 transition only.
module button_event #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // cnt tracks consecutive cycles the synchronized input differs from the accepted level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// Walks the tile grid in raster order, issuing one job at a time to the tile
// engine, with run and single-step modes driven by the start/step buttons.
module tile_scheduler
    import tile_pkg::*;
#(
    parameter int IMG_W     = tile_pkg::IMG_W,
    parameter int IMG_H     = tile_pkg::IMG_H,
    parameter int TILE      = tile_pkg::TILE,
    parameter int ADDR_W    = 18,
    parameter int DB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    output logic              tile_valid,
    input  logic              tile_ready,
    input  logic              tile_done,
    output logic [5:0]        tile_x,
    output logic [5:0]        tile_y,
    output logic [ADDR_W-1:0] tile_base_addr,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic [11:0]       tiles_completed
);

    localparam int TILES_X = IMG_W / TILE;
    localparam int TILES_Y = IMG_H / TILE;

    logic start_ev;
    logic step_ev;

    button_event #(.DB_CYCLES(DB_CYCLES)) u_start_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (start),
        .press (start_ev)
    );

    button_event #(.DB_CYCLES(DB_CYCLES)) u_step_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (step),
        .press (step_ev)
    );

    sched_state_t      state;
    mode_t             mode;
    mode_t             next_mode;
    logic              x_last;
    logic              y_last;
    logic [5:0]        next_x;
    logic [5:0]        next_y;
    logic [ADDR_W-1:0] next_base;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_mode = mode;
        if (start_ev) begin
            next_mode = RUN;
        end else if (step_ev) begin
            next_mode = STEP;
        end

        x_last    = (tile_x == 6'(TILES_X - 1));
        y_last    = (tile_y == 6'(TILES_Y - 1));
        next_x    = x_last ? 6'd0 : tile_x + 6'd1;
        next_y    = x_last ? tile_y + 6'd1 : tile_y;
        next_base = ADDR_W'(tile_base(next_x, next_y, TILE, IMG_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode            <= RUN;
            tile_x          <= '0;
            tile_y          <= '0;
            tile_base_addr  <= '0;
            tile_valid      <= 1'b0;
            busy            <= 1'b0;
            paused          <= 1'b0;
            done            <= 1'b0;
            tiles_completed <= '0;
        end else begin
            // Button events retarget the mode in every state; a job in flight is never aborted.
            mode <= next_mode;

            case (state)
                IDLE: begin
                    if (start_ev || step_ev) begin
                        state      <= ISSUE;
                        tile_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                ISSUE: begin
                    if (tile_ready) begin
                        state      <= WAIT_DONE;
                        tile_valid <= 1'b0;
                    end
                end

                WAIT_DONE: begin
                    if (tile_done) begin
                        state           <= ADVANCE;
                        busy            <= 1'b0;
                        tiles_completed <= tiles_completed + 12'd1;
                    end
                end

                ADVANCE: begin
                    if (x_last && y_last) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        tile_x         <= next_x;
                        tile_y         <= next_y;
                        tile_base_addr <= next_base;
                        if (next_mode == RUN) begin
                            state      <= ISSUE;
                            tile_valid <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state  <= PAUSE;
                            paused <= 1'b1;
                        end
                    end
                end

                PAUSE: begin
                    if (start_ev || step_ev) begin
                        state      <= ISSUE;
                        paused     <= 1'b0;
                        tile_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                FINISH: begin
                    if (start_ev || step_ev) begin
                        state           <= ISSUE;
                        done            <= 1'b0;
                        tiles_completed <= '0;
                        tile_x          <= '0;
                        tile_y          <= '0;
                        tile_base_addr  <= '0;
                        tile_valid      <= 1'b1;
                        busy            <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scheduler.sv
// Directed-plus-random bench for tile_scheduler on a 40x40 image with 10-pixel tiles.
module tb_tile_scheduler;

    localparam int IMG_W  = 40;
    localparam int IMG_H  = 40;
    localparam int TILE   = 10;
    localparam int ADDR_W = 18;
    localparam int DB     = 4;
    localparam int TX     = IMG_W / TILE;
    localparam int TY     = IMG_H / TILE;
    localparam int NT     = TX * TY;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              step = 1'b0;
    logic              tile_ready = 1'b1;
    logic              tile_done = 1'b0;
    logic              tile_valid;
    logic [5:0]        tile_x;
    logic [5:0]        tile_y;
    logic [ADDR_W-1:0] tile_base_addr;
    logic              busy;
    logic              paused;
    logic              done;
    logic [11:0]       tiles_completed;

    typedef struct {
        int x;
        int y;
        int base;
    } job_t;

    job_t jobs[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   inject_req = 0;

    tile_scheduler #(
        .IMG_W     (IMG_W),
        .IMG_H     (IMG_H),
        .TILE      (TILE),
        .ADDR_W    (ADDR_W),
        .DB_CYCLES (DB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .step            (step),
        .tile_valid      (tile_valid),
        .tile_ready      (tile_ready),
        .tile_done       (tile_done),
        .tile_x          (tile_x),
        .tile_y          (tile_y),
        .tile_base_addr  (tile_base_addr),
        .busy            (busy),
        .paused          (paused),
        .done            (done),
        .tiles_completed (tiles_completed)
    );

    always #5 clk = ~clk;

    // Engine model: logs each accepted job and pulses done 5 cycles after acceptance.
    initial begin
        int eng_cnt = 0;
        int inject_seen = 0;
        forever begin
            @(negedge clk);
            #2;
            tile_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else begin
                if (inject_seen != inject_req) begin
                    inject_seen = inject_req;
                    tile_done = 1'b1;
                end
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) tile_done = 1'b1;
                end
                if (tile_valid && tile_ready) begin
                    eng_cnt = 5;
                    jobs.push_back('{int'(tile_x), int'(tile_y), int'(tile_base_addr)});
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit s, input bit t, input int len);
        start = s;
        step  = t;
        cycles(len);
        start = 1'b0;
        step  = 1'b0;
        cycles(8);
    endtask

    task automatic wait_paused(input string tag, input int budget);
        int k = 0;
        while (!paused && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " paused reached"}, 32'(paused), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k = 0;
        while (!tile_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " valid reached"}, 32'(tile_valid), 32'd1);
    endtask

    task automatic wait_jobs(input string tag, input int n, input int budget);
        int k = 0;
        while (jobs.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, " jobs reached"}, 32'(jobs.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd, output int pcyc);
        int k = 0;
        pcyc = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            if (rnd) tile_ready = ($urandom_range(0, 3) != 0);
            if (paused) pcyc++;
            k++;
        end
        tile_ready = 1'b1;
        check({tag, " done reached"}, 32'(done), 32'd1);
    endtask

    // Reference: job k of a frame is tile (k mod TX, k div TX) in raster order.
    task automatic check_frame(input string tag);
        int n;
        check({tag, " job count"}, 32'(jobs.size()), 32'(NT));
        n = (jobs.size() < NT) ? jobs.size() : NT;
        for (int i = 0; i < n; i++) begin
            int ex = i % TX;
            int ey = i / TX;
            check($sformatf("%s job%0d x", tag, i), 32'(jobs[i].x), 32'(ex));
            check($sformatf("%s job%0d y", tag, i), 32'(jobs[i].y), 32'(ey));
            check($sformatf("%s job%0d base", tag, i), 32'(jobs[i].base),
                  32'(ey * TILE * IMG_W + ex * TILE));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tile_valid"}, 32'(tile_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " paused"}, 32'(paused), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " tiles_completed"}, 32'(tiles_completed), 32'd0);
        check({tag, " tile_x"}, 32'(tile_x), 32'd0);
        check({tag, " tile_y"}, 32'(tile_y), 32'd0);
        check({tag, " base"}, 32'(tile_base_addr), 32'd0);
    endtask

    initial begin
        int  pc;
        int  k;
        bit  stable;
        bit  prev_done;
        logic [5:0]        sx;
        logic [5:0]        sy;
        logic [ADDR_W-1:0] sb;

        // Reset state
        rst_n = 1'b0;
        cycles(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        cycles(2);

        // Step glitches shorter than the filter window must not produce an event
        repeat (3) begin
            step = 1'b1;
            cycles($urandom_range(1, 3));
            step = 1'b0;
            cycles($urandom_range(2, 5));
        end
        cycles(12);
        check("bounce tile_valid", 32'(tile_valid), 32'd0);
        check("bounce jobs", 32'(jobs.size()), 32'd0);

        // Start and step together from IDLE: run mode, whole frame without pausing
        press(1'b1, 1'b1, 6);
        wait_done("frameA", 400, 1'b0, pc);
        check("frameA paused cycles", 32'(pc), 32'd0);
        check_frame("frameA");
        check("frameA job(1,2) base", 32'(jobs[9].base), 32'd810);
        check("frameA job(3,3) base", 32'(jobs[15].base), 32'd1230);
        check("frameA tiles_completed", 32'(tiles_completed), 32'd16);
        cycles(10);
        check("frameA idle valid", 32'(tile_valid), 32'd0);
        check("frameA done held", 32'(done), 32'd1);

        // Back to IDLE, then single-step two tiles and resume with start
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        check("reidle done", 32'(done), 32'd0);
        jobs.delete();
        press(1'b0, 1'b1, 6);
        wait_paused("step1", 60);
        check("step1 jobs", 32'(jobs.size()), 32'd1);
        check("step1 tile_x", 32'(tile_x), 32'd1);
        check("step1 tile_y", 32'(tile_y), 32'd0);
        check("step1 tiles_completed", 32'(tiles_completed), 32'd1);
        check("step1 busy", 32'(busy), 32'd0);
        press(1'b0, 1'b1, 6);
        wait_paused("step2", 60);
        check("step2 jobs", 32'(jobs.size()), 32'd2);
        check("step2 job x", 32'(jobs[1].x), 32'd1);
        check("step2 job base", 32'(jobs[1].base), 32'd10);
        check("step2 tile_x", 32'(tile_x), 32'd2);
        press(1'b1, 1'b0, 6);
        wait_done("frameB", 400, 1'b0, pc);
        check("frameB paused cycles", 32'(pc), 32'd0);
        check_frame("frameB");

        // Start after done: done clears on the same edge that raises tile_valid
        jobs.delete();
        start = 1'b1;
        prev_done = done;
        k = 0;
        while (!tile_valid && k < 30) begin
            prev_done = done;
            @(negedge clk);
            k++;
        end
        check("restart valid reached", 32'(tile_valid), 32'd1);
        check("restart done before", 32'(prev_done), 32'd1);
        check("restart done cleared", 32'(done), 32'd0);
        check("restart tiles_completed", 32'(tiles_completed), 32'd0);
        check("restart tile_x", 32'(tile_x), 32'd0);
        start = 1'b0;

        // Step event lands while tile (2,0) is in WAIT_DONE
        wait_jobs("stepwait (1,0)", 2, 60);
        cycles(2);
        step = 1'b1;
        cycles(6);
        step = 1'b0;
        wait_paused("stepwait", 80);
        check("stepwait jobs", 32'(jobs.size()), 32'd3);
        check("stepwait tile_x", 32'(tile_x), 32'd3);
        check("stepwait tile_y", 32'(tile_y), 32'd0);
        check("stepwait tiles_completed", 32'(tiles_completed), 32'd3);
        cycles(8);

        // Engine stalls in ISSUE; a stray done pulse there is ignored
        tile_ready = 1'b0;
        press(1'b0, 1'b1, 6);
        wait_valid("stall", 30);
        sx = tile_x;
        sy = tile_y;
        sb = tile_base_addr;
        inject_req++;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!tile_valid || tile_x !== sx || tile_y !== sy || tile_base_addr !== sb)
                stable = 1'b0;
        end
        check("stall stable", 32'(stable), 32'd1);
        check("stall tile_x", 32'(tile_x), 32'd3);
        check("stall base", 32'(tile_base_addr), 32'd30);
        check("stall tiles_completed", 32'(tiles_completed), 32'd3);
        check("stall jobs", 32'(jobs.size()), 32'd3);
        tile_ready = 1'b1;
        wait_paused("after stall", 60);
        check("after stall tile_x", 32'(tile_x), 32'd0);
        check("after stall tile_y", 32'(tile_y), 32'd1);
        check("after stall tiles_completed", 32'(tiles_completed), 32'd4);

        // Resume in run mode with a randomly stalling engine
        press(1'b1, 1'b0, 6);
        wait_done("frameC", 1500, 1'b1, pc);
        check_frame("frameC");
        check("frameC tiles_completed", 32'(tiles_completed), 32'd16);

        // Asynchronous reset in the middle of tile 5
        jobs.delete();
        start = 1'b1;
        wait_valid("rerun", 30);
        start = 1'b0;
        wait_jobs("rerun tile5", 6, 200);
        cycles(2);
        check("midjob busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        jobs.delete();
        press(1'b1, 1'b0, 6);
        wait_jobs("post reset", 1, 40);
        check("post reset job x", 32'(jobs[0].x), 32'd0);
        check("post reset job y", 32'(jobs[0].y), 32'd0);
        check("post reset job base", 32'(jobs[0].base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
